// File: rtl/tapped_delay_pipe_pkg.sv
// Shared defaults and helpers for the tapped delay pipe.
package tapped_delay_pipe_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_DEPTH    = 6;
  localparam int unsigned DEF_NUM_TAPS = 4;

  // Index width needed to address n entries (at least 1 bit).
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

  // Power-up stage selection for tap t: tap t watches stage t, capped at the last stage.
  function automatic int unsigned reset_sel(input int unsigned t, input int unsigned depth);
    return (t < depth) ? t : depth - 1;
  endfunction

endpackage

// File: rtl/tapped_delay_pipe_stage.sv
// One valid+data pipeline register with sync reset, flush and hold.
// flush clears the valid bit but still moves data; flush and rst win over hold.
module delay_pipe_stage
  import tapped_delay_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  // Stage register: data shifts regardless of valid, valid dropped on flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (flush || !hold) begin
      q_valid <= d_valid & ~flush;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/tapped_delay_pipe.sv
// Programmable-latency delay line: launch register, DEPTH stages, NUM_TAPS
// independently selectable registered capture taps.
// Optional build macro DELAY_PIPE_STALL_EN adds a stall input that freezes
// the pipeline and tap outputs (cfg writes still apply; flush/rst override).
module tapped_delay_pipe
  import tapped_delay_pipe_pkg::*;
#(
  parameter  int unsigned WIDTH    = DEF_WIDTH,
  parameter  int unsigned DEPTH    = DEF_DEPTH,
  parameter  int unsigned NUM_TAPS = DEF_NUM_TAPS,
  localparam int unsigned SEL_W    = sel_width(DEPTH),
  localparam int unsigned TAP_W    = sel_width(NUM_TAPS)
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef DELAY_PIPE_STALL_EN
  input  logic                      stall,
`endif
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      flush,
  input  logic                      cfg_wr,
  input  logic [TAP_W-1:0]          cfg_tap,
  input  logic [SEL_W-1:0]          cfg_sel,
  output logic [NUM_TAPS-1:0]       out_valid,
  output logic [NUM_TAPS*WIDTH-1:0] out_data,
  output logic                      pipe_full
);

  logic             hold_c;
  logic             l_valid;
  logic [WIDTH-1:0] l_data;
  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] sdata [DEPTH];
  logic [SEL_W-1:0] sel [NUM_TAPS];
  logic [SEL_W-1:0] cfg_sel_clamped_c;

`ifdef DELAY_PIPE_STALL_EN
  assign hold_c = stall;
`else
  assign hold_c = 1'b0;
`endif

  // Out-of-range stage requests land on the last stage.
  assign cfg_sel_clamped_c = (32'(cfg_sel) >= DEPTH) ? SEL_W'(DEPTH - 1) : cfg_sel;

  delay_pipe_stage #(.WIDTH(WIDTH)) u_launch (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .hold    (hold_c),
    .d_valid (in_valid),
    .d_data  (in_data),
    .q_valid (l_valid),
    .q_data  (l_data)
  );

  // Stage chain: stage 0 takes the launch register, stage k takes stage k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      delay_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .hold    (hold_c),
        .d_valid (l_valid),
        .d_data  (l_data),
        .q_valid (vld[k]),
        .q_data  (sdata[k])
      );
    end else begin : g_rest
      delay_pipe_stage #(.WIDTH(WIDTH)) u_stage (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .hold    (hold_c),
        .d_valid (vld[k-1]),
        .d_data  (sdata[k-1]),
        .q_valid (vld[k]),
        .q_data  (sdata[k])
      );
    end
  end

  // Tap select registers; unmatched cfg_tap values write nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned t = 0; t < NUM_TAPS; t++) begin
        sel[t] <= SEL_W'(reset_sel(t, DEPTH));
      end
    end else if (cfg_wr) begin
      for (int unsigned t = 0; t < NUM_TAPS; t++) begin
        if (cfg_tap == TAP_W'(t)) begin
          sel[t] <= cfg_sel_clamped_c;
        end
      end
    end
  end

  // Tap capture registers and full flag; flush clears valids but data keeps moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= '0;
      out_data  <= '0;
      pipe_full <= 1'b0;
    end else if (flush || !hold_c) begin
      pipe_full <= (&vld) & ~flush;
      for (int unsigned t = 0; t < NUM_TAPS; t++) begin
        out_valid[t]               <= vld[sel[t]] & ~flush;
        out_data[t*WIDTH +: WIDTH] <= sdata[sel[t]];
      end
    end
  end

endmodule

// File: tb/tb_tapped_delay_pipe.sv
// Randomised and directed check of tapped_delay_pipe against a sample-history model.
module tb_tapped_delay_pipe;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned DEPTH    = 6;
  localparam int unsigned NUM_TAPS = 4;
  localparam int          HIST     = 4096;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      in_valid = 1'b0;
  logic [WIDTH-1:0]          in_data = '0;
  logic                      flush = 1'b0;
  logic                      cfg_wr = 1'b0;
  logic [1:0]                cfg_tap = '0;
  logic [2:0]                cfg_sel = '0;
  logic [NUM_TAPS-1:0]       out_valid;
  logic [NUM_TAPS*WIDTH-1:0] out_data;
  logic                      pipe_full;
`ifdef DELAY_PIPE_STALL_EN
  logic                      stall = 1'b0;
`endif

  tapped_delay_pipe dut (
    .clk       (clk),
    .rst       (rst),
`ifdef DELAY_PIPE_STALL_EN
    .stall     (stall),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .flush     (flush),
    .cfg_wr    (cfg_wr),
    .cfg_tap   (cfg_tap),
    .cfg_sel   (cfg_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .pipe_full (pipe_full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: every pipeline advance launches one history entry; stage k after
  // advance a holds entry a-1-k, tap output after advance a shows entry a-2-sel.
  bit         hv [HIST];
  logic [7:0] hd [HIST];
  int         a = -1;
  int         sel_m [NUM_TAPS];
  bit         ev [NUM_TAPS];
  logic [7:0] ed [NUM_TAPS];
  bit         ep = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit get_v(input int j);
    return (j < 0) ? 1'b0 : hv[j];
  endfunction

  function automatic logic [7:0] get_d(input int j);
    return (j < 0) ? 8'h00 : hd[j];
  endfunction

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit iv, input logic [7:0] id, input bit fl,
                      input bit cw, input logic [1:0] ct, input logic [2:0] cs, input bit st);
    bit adv;
    rst = r; in_valid = iv; in_data = id; flush = fl;
    cfg_wr = cw; cfg_tap = ct; cfg_sel = cs;
`ifdef DELAY_PIPE_STALL_EN
    stall = st;
`endif
    adv = r || fl || !st;
    if (adv && a < HIST - 1) begin
      a++;
      hv[a] = iv && !fl;
      hd[a] = id;
      for (int j = a - int'(DEPTH) - 4; j <= a; j++) begin
        if (j >= 0) begin
          if (r) begin
            hv[j] = 1'b0;
            hd[j] = 8'h00;
          end else if (fl) begin
            hv[j] = 1'b0;
          end
        end
      end
      ep = 1'b1;
      for (int k = 0; k < int'(DEPTH); k++) ep = ep & get_v(a - 2 - k);
      for (int t = 0; t < int'(NUM_TAPS); t++) begin
        ev[t] = get_v(a - 2 - sel_m[t]);
        ed[t] = get_d(a - 2 - sel_m[t]);
      end
    end
    if (r) begin
      for (int t = 0; t < int'(NUM_TAPS); t++) sel_m[t] = (t < int'(DEPTH)) ? t : int'(DEPTH) - 1;
    end else if (cw) begin
      sel_m[int'(ct)] = (int'(cs) >= int'(DEPTH)) ? int'(DEPTH) - 1 : int'(cs);
    end
    @(posedge clk);
    #1;
    for (int t = 0; t < int'(NUM_TAPS); t++) begin
      chk($sformatf("tap%0d_valid", t), 32'(out_valid[t]), 32'(ev[t]));
      chk($sformatf("tap%0d_data", t), 32'(out_data[t*WIDTH +: WIDTH]), 32'(ed[t]));
    end
    chk("pipe_full", 32'(pipe_full), 32'(ep));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic push(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
  endtask

  task automatic cfg(input logic [1:0] t, input logic [2:0] s);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, t, s, 1'b0);
  endtask

  initial begin
    int c;
    bit found;

    // Reset with default selects.
    for (int t = 0; t < int'(NUM_TAPS); t++) sel_m[t] = t;
    repeat (2) step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);

    // Back-to-back stream 0x01..0x10 through default taps.
    for (int i = 1; i <= 16; i++) push(8'(i));
    repeat (10) idle();

    // Tap 2 moved to the last stage: single sample latency.
    cfg(2'd2, 3'd5);
    idle();
    push(8'hA5);
    c = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      idle();
      c++;
      if (out_valid[2] === 1'b1) found = 1'b1;
    end
    chk("tap2_latency", found ? 32'(c) : 32'd0, 32'd8);
    chk("tap2_late_data", 32'(out_data[2*WIDTH +: WIDTH]), 32'hA5);
    repeat (4) idle();

    // Out-of-range stage select clamps to the last stage.
    cfg(2'd1, 3'd7);
    for (int i = 0; i < 12; i++) push(8'(8'h40 + i));
    repeat (10) idle();

    // Flush in the middle of a stream.
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b1, 8'(8'h80 + i), (i == 4), 1'b0, 2'd0, 3'd0, 1'b0);
    repeat (10) idle();

    // Flush and cfg write on the same cycle.
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    step(1'b0, 1'b1, 8'hCF, 1'b1, 1'b1, 2'd3, 3'd1, 1'b0);
    for (int i = 0; i < 10; i++) push(8'(8'hD0 + i));

    // Reset mid-stream with custom selects, then confirm defaults restored.
    cfg(2'd0, 3'd4);
    cfg(2'd3, 3'd0);
    for (int i = 0; i < 9; i++) push(8'(8'h20 + i));
    step(1'b1, 1'b1, 8'h29, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
    for (int i = 0; i < 12; i++) push(8'(8'h60 + i));
    repeat (10) idle();

`ifdef DELAY_PIPE_STALL_EN
    // Stall for three cycles mid-stream.
    for (int i = 0; i < 16; i++)
      step(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0, 1'b0, 2'd0, 3'd0, (i >= 5 && i < 8));
    repeat (10) idle();
`endif

    // Randomised traffic with occasional config, flush and reset.
    for (int i = 0; i < 800; i++) begin
      bit st;
      st = 1'b0;
`ifdef DELAY_PIPE_STALL_EN
      st = ($urandom_range(0, 4) == 0);
`endif
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           8'($urandom),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)),
           st);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
